// File: rtl/otp_pkg.sv
// Shared types and constants for the OTP antifuse array controller:
// FSM state encoding, host mode encodings and default timing constants.
package otp_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PRG_SETUP,
        PRG_PULSE,
        PRG_VERIFY,
        PRG_NEXT,
        RD_SETUP,
        RD_SENSE,
        RD_NEXT,
        DONE
    } otp_state_t;

    localparam logic [1:0] MODE_IDLE = 2'd0;
    localparam logic [1:0] MODE_PRG  = 2'd1;
    localparam logic [1:0] MODE_READ = 2'd2;

    localparam int DEF_PULSE_CYCLES = 4;
    localparam int DEF_SENSE_CYCLES = 2;
    localparam int DEF_MAX_RETRY    = 3;

endpackage

// File: rtl/otp_line_decode.sv
// One-hot decoder from {state, row index, column} to the array drive lines.
// Program lines and sense lines are asserted in disjoint states only.
module otp_line_decode
    import otp_pkg::*;
#(
    parameter int A          = 2,
    parameter int B          = 2,
    parameter int BIT_W      = 1,
    parameter int ADDR_WIDTH = 1
) (
    input  otp_state_t            i_state,
    input  logic [BIT_W-1:0]      i_bit,
    input  logic [ADDR_WIDTH-1:0] i_col,
    output logic [2*B-1:0]        o_pl,
    output logic [B-1:0]          o_bl,
    output logic [A-1:0]          o_wln,
    output logic [A-1:0]          o_wlp
);

    logic [B-1:0] w_colHot;
    logic [A-1:0] w_rowHot;

    always_comb begin
        w_colHot = '0;
        w_rowHot = '0;
        for (int c = 0; c < B; c++) begin
            w_colHot[c] = (int'(i_col) == c);
        end
        for (int r = 0; r < A; r++) begin
            w_rowHot[r] = (int'(i_bit) == r);
        end
    end

    // Each column owns a gate-enable / high-voltage-enable pair of program lines
    always_comb begin
        o_pl  = '0;
        o_bl  = '0;
        o_wln = '0;
        o_wlp = '0;
        case (i_state)
            PRG_PULSE: begin
                o_wlp = w_rowHot;
                for (int c = 0; c < B; c++) begin
                    o_pl[2*c +: 2] = {2{w_colHot[c]}};
                end
            end
            PRG_VERIFY, RD_SENSE: begin
                o_wln = w_rowHot;
                o_bl  = w_colHot;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/otp_ctrl_fsm.sv
// Program/verify/read sequencer for an A-row x B-column antifuse OTP array.
// All drive lines are registered copies of the decoded current state.
module otp_ctrl_fsm
    import otp_pkg::*;
#(
    parameter int   A            = 2,
    parameter int   B            = 2,
    parameter int   PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int   SENSE_CYCLES = DEF_SENSE_CYCLES,
    parameter int   MAX_RETRY    = DEF_MAX_RETRY,
    localparam int  ADDR_WIDTH   = (B > 1) ? $clog2(B) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] column,
    input  logic [A-1:0]          data_in,
    input  logic                  writing_successful,
    output logic [2*B-1:0]        PL,
    output logic [B-1:0]          BL,
    output logic [A-1:0]          WLN,
    output logic [A-1:0]          WLP,
    output logic                  read_active,
    output logic [A-1:0]          data_out
);

    localparam int BIT_W   = (A > 1) ? $clog2(A) : 1;
    localparam int CNT_MAX = (PULSE_CYCLES > SENSE_CYCLES) ? PULSE_CYCLES : SENSE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0]   PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   SENSE_LAST = CNT_W'(SENSE_CYCLES - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(A - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM  = RETRY_W'(MAX_RETRY);

    otp_state_t            r_state, w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [BIT_W-1:0]      r_bit;
    logic [RETRY_W-1:0]    r_retry;
    logic [ADDR_WIDTH-1:0] r_col;
    logic [A-1:0]          r_data;
    logic [1:0]            r_startMode;
    logic [2*B-1:0]        r_pl;
    logic [B-1:0]          r_bl;
    logic [A-1:0]          r_wln, r_wlp, r_dataOut;
    logic                  r_readActive;

    logic [1:0]            w_mode;
    logic                  w_abort;
    logic [2*B-1:0]        w_pl;
    logic [B-1:0]          w_bl;
    logic [A-1:0]          w_wln, w_wlp;

    otp_line_decode #(
        .A          (A),
        .B          (B),
        .BIT_W      (BIT_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_decode (
        .i_state (r_state),
        .i_bit   (r_bit),
        .i_col   (r_col),
        .o_pl    (w_pl),
        .o_bl    (w_bl),
        .o_wln   (w_wln),
        .o_wlp   (w_wlp)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Reserved mode 3 behaves like idle; idle during an active state aborts
    always_comb begin
        w_mode  = (mode == MODE_PRG || mode == MODE_READ) ? mode : MODE_IDLE;
        w_abort = (r_state != IDLE) && (r_state != DONE) && (w_mode == MODE_IDLE);
        w_next  = r_state;
        case (r_state)
            IDLE: begin
                if (w_mode == MODE_PRG)       w_next = PRG_SETUP;
                else if (w_mode == MODE_READ) w_next = RD_SETUP;
            end
            PRG_SETUP:  w_next = r_data[r_bit] ? PRG_PULSE : PRG_NEXT;
            PRG_PULSE:  if (r_cnt == PULSE_LAST) w_next = PRG_VERIFY;
            PRG_VERIFY: begin
                if (r_cnt == SENSE_LAST)
                    w_next = (!writing_successful && r_retry < RETRY_LIM) ? PRG_PULSE : PRG_NEXT;
            end
            PRG_NEXT:   w_next = (r_bit == BIT_LAST) ? DONE : PRG_SETUP;
            RD_SETUP:   w_next = RD_SENSE;
            RD_SENSE:   if (r_cnt == SENSE_LAST) w_next = RD_NEXT;
            RD_NEXT:    w_next = (r_bit == BIT_LAST) ? DONE : RD_SETUP;
            DONE:       if (mode != r_startMode) w_next = IDLE;
            default:    w_next = IDLE;
        endcase
        if (w_abort) w_next = IDLE;
    end

    // Operands are captured continuously while idle so they freeze on entry
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_bit        <= '0;
            r_retry      <= '0;
            r_col        <= '0;
            r_data       <= '0;
            r_startMode  <= MODE_IDLE;
            r_pl         <= '0;
            r_bl         <= '0;
            r_wln        <= '0;
            r_wlp        <= '0;
            r_readActive <= 1'b0;
            r_dataOut    <= '0;
        end else begin
            r_cnt <= (w_next != r_state || r_state == IDLE || r_state == DONE) ? '0 : r_cnt + 1'b1;
            if (r_state == IDLE) begin
                r_col       <= column;
                r_data      <= data_in;
                r_bit       <= '0;
                r_retry     <= '0;
                r_startMode <= w_mode;
            end
            if (r_state == PRG_VERIFY && w_next == PRG_PULSE) r_retry <= r_retry + 1'b1;
            if ((r_state == PRG_NEXT && w_next == PRG_SETUP) ||
                (r_state == RD_NEXT && w_next == RD_SETUP)) begin
                r_bit   <= r_bit + 1'b1;
                r_retry <= '0;
            end
            if (r_state == RD_SENSE && w_next == RD_NEXT) r_dataOut[r_bit] <= writing_successful;
            r_pl         <= w_abort ? '0 : w_pl;
            r_bl         <= w_abort ? '0 : w_bl;
            r_wln        <= w_abort ? '0 : w_wln;
            r_wlp        <= w_abort ? '0 : w_wlp;
            r_readActive <= !w_abort && (r_state == RD_SETUP || r_state == RD_SENSE || r_state == RD_NEXT);
        end
    end

    assign PL          = r_pl;
    assign BL          = r_bl;
    assign WLN         = r_wln;
    assign WLP         = r_wlp;
    assign read_active = r_readActive;
    assign data_out    = r_dataOut;

endmodule

// File: tb/tb_otp_ctrl_fsm.sv
// Scoreboard bench for otp_ctrl_fsm: expected line bursts and read results are
// queued by the stimulus thread and popped by a negedge monitor.
module tb_otp_ctrl_fsm;
    import otp_pkg::*;

    localparam int A  = 2;
    localparam int B  = 2;
    localparam int LW = 2*B + B + 2*A;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   mode;
    logic         column;
    logic [A-1:0] data_in;
    logic         writing_successful;
    logic [2*B-1:0] PL;
    logic [B-1:0] BL;
    logic [A-1:0] WLN, WLP, data_out;
    logic         read_active;

    logic [A-1:0] cellMask;
    logic         wsRandOn, wsRand;
    bit           scoreOn = 1'b1;

    typedef struct { logic [LW-1:0] lines; int len; } burst_t;
    typedef struct { logic [A-1:0] data; int len; } read_t;
    burst_t burstQ[$];
    read_t  readQ[$];
    int checks   = 0;
    int failures = 0;

    otp_ctrl_fsm #(.A(A), .B(B), .PULSE_CYCLES(4), .SENSE_CYCLES(2), .MAX_RETRY(3)) dut (
        .clk                (clk),
        .reset              (reset),
        .mode               (mode),
        .column             (column),
        .data_in            (data_in),
        .writing_successful (writing_successful),
        .PL                 (PL),
        .BL                 (BL),
        .WLN                (WLN),
        .WLP                (WLP),
        .read_active        (read_active),
        .data_out           (data_out)
    );

    always #5 clk = ~clk;

    // Array model: the addressed cell conducts if its row is selected and it is blown
    assign writing_successful = wsRandOn ? wsRand : |(WLN & cellMask);

    // Line vector layout is {PL, BL, WLN, WLP}
    function automatic logic [LW-1:0] pulseVec(input int col, input int row);
        logic [LW-1:0] v = '0;
        v[6 + 2*col] = 1'b1;
        v[7 + 2*col] = 1'b1;
        v[row]       = 1'b1;
        return v;
    endfunction

    function automatic logic [LW-1:0] senseVec(input int col, input int row);
        logic [LW-1:0] v = '0;
        v[4 + col] = 1'b1;
        v[2 + row] = 1'b1;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushBurst(input logic [LW-1:0] v, input int len);
        burst_t b;
        b.lines = v;
        b.len   = len;
        burstQ.push_back(b);
    endtask

    task automatic pushRead(input logic [A-1:0] d, input int len);
        read_t r;
        r.data = d;
        r.len  = len;
        readQ.push_back(r);
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic c, input logic [A-1:0] d,
                                 input logic [A-1:0] cells);
        @(negedge clk);
        column   = c;
        data_in  = d;
        cellMask = cells;
        mode     = m;
    endtask

    task automatic waitState(input otp_state_t s, input int budget, input string name);
        int n = 0;
        while (dut.r_state != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(int'(dut.r_state)), 32'(int'(s)));
    endtask

    // Monitor: safety invariant every cycle, then burst and read-result scoreboard
    logic [LW-1:0] curLines = '0;
    int runLen = 0;
    int raLen  = 0;
    always @(negedge clk) begin
        logic [LW-1:0] lines;
        burst_t eb;
        read_t  er;
        lines = {PL, BL, WLN, WLP};
        checkOutput("safety invariant",
                    32'(((|PL || |WLP) && (|WLN || |BL)) || !$onehot0(WLP) || !$onehot0(WLN) || !$onehot0(BL)),
                    32'd0);
        if (reset || !scoreOn) begin
            curLines = '0;
            runLen   = 0;
            raLen    = 0;
        end else begin
            if (lines != curLines) begin
                if (curLines != '0) begin
                    if (burstQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected burst: got lines 0x%0h len %0d, expected none", curLines, runLen);
                    end else begin
                        eb = burstQ.pop_front();
                        checkOutput("burst lines", 32'(curLines), 32'(eb.lines));
                        checkOutput("burst length", 32'(runLen), 32'(eb.len));
                    end
                end
                curLines = lines;
                runLen   = (lines != '0) ? 1 : 0;
            end else if (lines != '0) begin
                runLen++;
            end
            if (read_active) begin
                raLen++;
            end else if (raLen > 0) begin
                if (readQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected read: got data_out 0x%0h, expected none", data_out);
                end else begin
                    er = readQ.pop_front();
                    checkOutput("read data_out", 32'(data_out), 32'(er.data));
                    checkOutput("read_active length", 32'(raLen), 32'(er.len));
                end
                raLen = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1; mode = 2'd1; column = 1'b0; data_in = '0;
        cellMask = '0; wsRandOn = 1'b0; wsRand = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset lines", 32'({PL, BL, WLN, WLP}), 32'd0);
        checkOutput("reset read_active", 32'(read_active), 32'd0);
        checkOutput("reset data_out", 32'(data_out), 32'd0);
        checkOutput("reset state", 32'(int'(dut.r_state)), 32'(int'(IDLE)));

        // Program of an all-zero word never pulses and finishes quickly
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("zero word PL/WLP", 32'({PL, WLP}), 32'd0);
        end
        checkOutput("zero word reaches DONE", 32'(int'(dut.r_state)), 32'(int'(DONE)));
        mode = 2'd0;
        repeat (2) @(negedge clk);

        // Program 11 into column 1, every verify succeeds
        for (int r = 0; r < A; r++) begin
            pushBurst(pulseVec(1, r), 4);
            pushBurst(senseVec(1, r), 2);
        end
        applyStimulus(2'd1, 1'b1, 2'b11, 2'b11);
        waitState(DONE, 60, "program ok reaches DONE");
        repeat (3) @(negedge clk);
        checkOutput("program ok holds DONE", 32'(int'(dut.r_state)), 32'(int'(DONE)));
        checkOutput("DONE lines low", 32'({PL, BL, WLN, WLP}), 32'd0);
        mode = 2'd0;
        repeat (2) @(negedge clk);
        checkOutput("DONE returns IDLE", 32'(int'(dut.r_state)), 32'(int'(IDLE)));

        // Program 11 into column 1, every verify fails: 1 pulse + 3 retries per row
        for (int r = 0; r < A; r++) begin
            for (int t = 0; t < 4; t++) begin
                pushBurst(pulseVec(1, r), 4);
                pushBurst(senseVec(1, r), 2);
            end
        end
        applyStimulus(2'd1, 1'b1, 2'b11, 2'b00);
        waitState(DONE, 120, "program retry reaches DONE");
        mode = 2'd0;
        repeat (2) @(negedge clk);

        // Read column 0 with row 0 programmed and row 1 blank
        pushBurst(senseVec(0, 0), 2);
        pushBurst(senseVec(0, 1), 2);
        pushRead(2'b01, 8);
        applyStimulus(2'd2, 1'b0, 2'b00, 2'b01);
        waitState(DONE, 40, "read reaches DONE");
        mode = 2'd0;
        repeat (3) @(negedge clk);
        checkOutput("data_out holds", 32'(data_out), 32'h1);

        // Abort in the middle of a program pulse
        pushBurst(pulseVec(0, 0), 2);
        applyStimulus(2'd1, 1'b0, 2'b01, 2'b11);
        n = 0;
        @(negedge clk);
        while (PL == '0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort pulse seen", 32'(PL != '0), 32'd1);
        @(negedge clk);
        mode = 2'd0;
        @(negedge clk);
        checkOutput("abort lines low", 32'({PL, BL, WLN, WLP}), 32'd0);
        checkOutput("abort state IDLE", 32'(int'(dut.r_state)), 32'(int'(IDLE)));
        repeat (2) @(negedge clk);

        // Full read of column 1 then reset during a second read
        pushBurst(senseVec(1, 0), 2);
        pushBurst(senseVec(1, 1), 2);
        pushRead(2'b11, 8);
        applyStimulus(2'd2, 1'b1, 2'b00, 2'b11);
        waitState(DONE, 40, "read col1 reaches DONE");
        mode = 2'd0;
        repeat (2) @(negedge clk);
        mode = 2'd2;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mode  = 2'd0;
        @(negedge clk);
        checkOutput("reset mid-read data_out", 32'(data_out), 32'd0);
        checkOutput("reset mid-read lines", 32'({PL, BL, WLN, WLP}), 32'd0);
        checkOutput("reset mid-read read_active", 32'(read_active), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Random traffic; only the safety invariant is checked here
        scoreOn  = 1'b0;
        wsRandOn = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            column  = 1'($urandom_range(0, 1));
            data_in = A'($urandom);
            wsRand  = 1'($urandom);
        end
        mode     = 2'd0;
        wsRandOn = 1'b0;
        reset    = 1'b1;
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        @(negedge clk);

        checkOutput("burst queue drained", 32'(burstQ.size()), 32'd0);
        checkOutput("read queue drained", 32'(readQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
